decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/rv_pkg.sv | 73 +++++++
 rtl/rv_decode_comb.sv | 124 ++++++++++++
 rtl/decode_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, immediate formats and control bundle.
// Optional RV32M_EN adds the M-extension muldiv flag to the bundle.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_OP  = 2'b10;
    localparam logic [1:0] ALUOP_OPI = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SR     = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       illegal;
`ifdef RV32M_EN
        logic       is_muldiv;
`endif
        logic [1:0] alu_op;
    } ctrl_t;

    // Assemble the 32-bit immediate of the given format.
    function automatic logic [31:0] imm_gen(
        input logic [31:0] w,
        input imm_fmt_e    f
    );
        logic [31:0] r;
        case (f)
            IMM_I:   r = {{20{w[31]}}, w[31:20]};
            IMM_S:   r = {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_B:   r = {{19{w[31]}}, w[31], w[7],
                          w[30:25], w[11:8], 1'b0};
            IMM_U:   r = {w[31:12], 12'b0};
            IMM_J:   r = {{11{w[31]}}, w[31], w[19:12],
                          w[20], w[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I field, control and immediate decode.
// With RV32M_EN, OP funct7=0000001 decodes as a legal muldiv.
module rv_decode_comb
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [6:0]      opcode
);

    imm_fmt_e    fmt;
    logic [31:0] imm32;
    logic        shift_bad;
    logic        op_ok;
    logic        is_md;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign shamt  = instr[24:20];
    assign funct7 = instr[31:25];

`ifdef RV32M_EN
    assign is_md = (funct7 == F7_MULDIV);
`else
    assign is_md = 1'b0;
`endif

    // Shift immediates only allow the logical/arithmetic funct7 codes.
    assign shift_bad =
        ((funct3 == F3_SLL) && (funct7 != F7_BASE)) ||
        ((funct3 == F3_SR) && (funct7 != F7_BASE)
                           && (funct7 != F7_ALT));

    assign op_ok =
        (funct7 == F7_BASE) ||
        ((funct7 == F7_ALT) &&
         ((funct3 == F3_ADDSUB) || (funct3 == F3_SR))) ||
        is_md;

    // Opcode decode into control bundle and immediate format.
    always_comb begin
        ctrl = '0;
        fmt  = IMM_NONE;
        unique case (1'b1)
            (opcode == OPC_LUI),
            (opcode == OPC_AUIPC): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                fmt            = IMM_U;
            end
            (opcode == OPC_JAL): begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                fmt            = IMM_J;
            end
            (opcode == OPC_JALR): begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.alu_src   = 1'b1;
                fmt            = IMM_I;
            end
            (opcode == OPC_BRANCH): begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
                fmt         = IMM_B;
            end
            (opcode == OPC_LOAD): begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                fmt             = IMM_I;
            end
            (opcode == OPC_STORE): begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                fmt            = IMM_S;
            end
            (opcode == OPC_OPIMM): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_OPI;
                ctrl.illegal   = shift_bad;
                fmt            = IMM_I;
            end
            (opcode == OPC_OP): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_OP;
                ctrl.illegal   = !op_ok;
`ifdef RV32M_EN
                ctrl.is_muldiv = is_md;
`endif
            end
            (opcode == OPC_MISC),
            (opcode == OPC_SYSTEM): begin
                fmt = IMM_I;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        if (ctrl.illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            fmt          = IMM_NONE;
        end
    end

    assign imm32 = imm_gen(instr, fmt);
    assign imm   = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: valid/ready output register plus illegal counter.
// Define RV32M_EN to decode the M extension and expose is_muldiv.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [6:0]       opcode,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             Branch,
    output logic             Jump,
    output logic             illegal,
    output logic [1:0]       ALUOp,
`ifdef RV32M_EN
    output logic             is_muldiv,
`endif
    output logic [CNT_W-1:0] illegal_cnt
);

    ctrl_t           d_ctrl;
    ctrl_t           q_ctrl;
    logic [XLEN-1:0] d_imm;
    logic [4:0]      d_rs1;
    logic [4:0]      d_rs2;
    logic [4:0]      d_rd;
    logic [4:0]      d_shamt;
    logic [2:0]      d_funct3;
    logic [6:0]      d_funct7;
    logic [6:0]      d_opcode;
    logic            accept;
    logic            load;

    rv_decode_comb #(
        .XLEN (XLEN)
    ) u_dec (
        .instr  (in_instr),
        .ctrl   (d_ctrl),
        .imm    (d_imm),
        .rs1    (d_rs1),
        .rs2    (d_rs2),
        .rd     (d_rd),
        .shamt  (d_shamt),
        .funct3 (d_funct3),
        .funct7 (d_funct7),
        .opcode (d_opcode)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign load     = accept && !flush;

    // Output register: flush kills, accept loads, consume drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q_ctrl    <= '0;
            out_pc    <= '0;
            imm       <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            shamt     <= '0;
            funct3    <= '0;
            funct7    <= '0;
            opcode    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q_ctrl    <= d_ctrl;
            out_pc    <= in_pc;
            imm       <= d_imm;
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            rd        <= d_rd;
            shamt     <= d_shamt;
            funct3    <= d_funct3;
            funct7    <= d_funct7;
            opcode    <= d_opcode;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of accepted, unflushed illegal instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (load && d_ctrl.illegal && !(&illegal_cnt)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign RegWrite = q_ctrl.reg_write;
    assign MemRead  = q_ctrl.mem_read;
    assign MemWrite = q_ctrl.mem_write;
    assign MemtoReg = q_ctrl.mem_to_reg;
    assign ALUSrc   = q_ctrl.alu_src;
    assign Branch   = q_ctrl.branch;
    assign Jump     = q_ctrl.jump;
    assign illegal  = q_ctrl.illegal;
    assign ALUOp    = q_ctrl.alu_op;
`ifdef RV32M_EN
    assign is_muldiv = q_ctrl.is_muldiv;
`endif

endmodule
